// File: rtl/mmm_final_reducer_if.sv
// mmm_final_reducer_if: operand/result handshake bundle for the final reducer.
interface mmm_final_reducer_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   t_in;
    logic [WIDTH-1:0] m_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r_out;
    logic             subtracted;
    logic             busy;
    modport master (
        output in_valid, t_in, m_in, out_ready,
        input  in_ready, out_valid, r_out, subtracted, busy
    );
    modport slave (
        input  in_valid, t_in, m_in, out_ready,
        output in_ready, out_valid, r_out, subtracted, busy
    );
endinterface

// File: rtl/mmm_final_reducer.sv
// mmm_final_reducer: bit-serial conditional final subtraction R = T mod M for T < 2M.
module mmm_final_reducer #(parameter int WIDTH = 8) (
    input logic                clk,
    input logic                rst_n,
    mmm_final_reducer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH:0]   t_sh_q, t_sh_d, m_sh_q, m_sh_d;
    logic [WIDTH-1:0] t_keep_q, t_keep_d, diff_q, diff_d, r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d, sub_q, sub_d, rdy_q, d_bit, b_nxt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            t_sh_q   <= '0;
            m_sh_q   <= '0;
            t_keep_q <= '0;
            diff_q   <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            sub_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_sh_q   <= t_sh_d;
            m_sh_q   <= m_sh_d;
            t_keep_q <= t_keep_d;
            diff_q   <= diff_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            sub_q    <= sub_d;
            rdy_q    <= 1'b1;
        end
    end
    assign d_bit = t_sh_q[0] ^ m_sh_q[0] ^ borrow_q;
    assign b_nxt = (~t_sh_q[0] & m_sh_q[0]) | (~(t_sh_q[0] ^ m_sh_q[0]) & borrow_q);
    // diff holds the low WIDTH difference bits once WIDTH bits are shifted in;
    // the final (WIDTH-th) bit only feeds the borrow that picks the result.
    always_comb begin
        state_d  = state_q;
        t_sh_d   = t_sh_q;
        m_sh_d   = m_sh_q;
        t_keep_d = t_keep_q;
        diff_d   = diff_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        sub_d    = sub_q;
        case (state_q)
            IDLE: if (bus.in_valid && rdy_q) begin
                t_sh_d   = bus.t_in;
                t_keep_d = bus.t_in[WIDTH-1:0];
                m_sh_d   = {1'b0, bus.m_in};
                diff_d   = '0;
                borrow_d = 1'b0;
                cnt_d    = '0;
                state_d  = SUB;
            end
            SUB: begin
                t_sh_d   = {1'b0, t_sh_q[WIDTH:1]};
                m_sh_d   = {1'b0, m_sh_q[WIDTH:1]};
                diff_d   = {d_bit, diff_q[WIDTH-1:1]};
                borrow_d = b_nxt;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH)) begin
                    state_d = DONE;
                    r_d     = b_nxt ? t_keep_q : diff_q;
                    sub_d   = ~b_nxt;
                end
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    assign bus.in_ready   = rdy_q && state_q == IDLE;
    assign bus.out_valid  = state_q == DONE;
    assign bus.busy       = state_q == SUB || state_q == DONE;
    assign bus.r_out      = r_q;
    assign bus.subtracted = sub_q;
endmodule

// File: tb/tb_mmm_final_reducer.sv
// tb_mmm_final_reducer: vector table, corner sequences and randomized scoreboard run.
module tb_mmm_final_reducer;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    mmm_final_reducer_if #(.WIDTH(W)) bus ();
    mmm_final_reducer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {int t; int m; int r; int s;} vec_t;
    vec_t vecs[9];
    int exp_r_q[$];
    int exp_s_q[$];
    int got;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: one conditional subtraction, result truncated to W bits.
    function automatic void ref_model(input int t, input int m, output int r, output int s);
        s = (t >= m) ? 1 : 0;
        r = s ? ((t - m) % (1 << W)) : t;
    endfunction

    task automatic present(input int t, input int m);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.t_in = (W+1)'(t);
        bus.m_in = W'(m);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept", int'(bus.in_ready), 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.out_valid) break;
        end
    endtask

    task automatic run_op(input int t, input int m, input int er, input int es);
        int n;
        bus.out_ready = 1'b1;
        present(t, m);
        wait_valid(n);
        chk("latency", n, W + 1);
        chk("r_out", int'(bus.r_out), er);
        chk("subtracted", int'(bus.subtracted), es);
        chk("busy_done", int'(bus.busy), 1);
        @(negedge clk);
        chk("post_hs_valid", int'(bus.out_valid), 0);
        chk("post_hs_ready", int'(bus.in_ready), 1);
        chk("r_out_kept", int'(bus.r_out), er);
    endtask

    initial begin
        int n, r, s, cyc;
        bit seen;
        bus.in_valid = 1'b0;
        bus.t_in = '0;
        bus.m_in = '0;
        bus.out_ready = 1'b0;
        vecs = '{'{300, 200, 100, 1}, '{150, 200, 150, 0}, '{200, 200, 0, 1},
                 '{399, 200, 199, 1}, '{255, 0, 255, 1}, '{511, 256 % 256, 255, 1},
                 '{1, 1, 0, 1}, '{0, 5, 0, 0}, '{509, 255, 254, 1}};
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_r_out", int'(bus.r_out), 0);
        chk("rst_sub", int'(bus.subtracted), 0);
        chk("rst_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", int'(bus.in_ready), 1);

        foreach (vecs[i]) run_op(vecs[i].t, vecs[i].m, vecs[i].r, vecs[i].s);

        // Backpressure: result held, new operand ignored while DONE.
        bus.out_ready = 1'b0;
        present(256, 255);
        wait_valid(n);
        chk("bp_latency", n, W + 1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", int'(bus.out_valid), 1);
            chk("bp_r_out", int'(bus.r_out), 1);
            chk("bp_sub", int'(bus.subtracted), 1);
            if (k == 1) begin
                bus.in_valid = 1'b1;
                bus.t_in = 9'd10;
                bus.m_in = 8'd7;
            end
            if (k > 1) chk("bp_in_ready", int'(bus.in_ready), 0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_released", int'(bus.out_valid), 0);
        run_op(10, 255, 10, 0);

        // Reset in the middle of SUB discards the operand.
        present(300, 200);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_ready", int'(bus.in_ready), 0);
        chk("mid_rst_valid", int'(bus.out_valid), 0);
        chk("mid_rst_r", int'(bus.r_out), 0);
        chk("mid_rst_sub", int'(bus.subtracted), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("no_stale_result", int'(seen), 0);
        run_op(511, 256 % 256, 255, 1);
        run_op(511, 128, 127, 1);

        // Randomized back-to-back traffic against the reference model.
        got = 0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    int m, t, er, es;
                    m = $urandom_range(1, 255);
                    t = $urandom_range(0, 2 * m - 1);
                    ref_model(t, m, er, es);
                    @(negedge clk);
                    bus.in_valid = 1'b1;
                    bus.t_in = (W+1)'(t);
                    bus.m_in = W'(m);
                    n = 0;
                    while (!bus.in_ready && n < 100) begin
                        @(negedge clk);
                        n++;
                    end
                    if (n >= 100) begin
                        chk("rand_accept_timeout", n, 0);
                        break;
                    end
                    exp_r_q.push_back(er);
                    exp_s_q.push_back(es);
                    @(posedge clk);
                    #1 bus.in_valid = 1'b0;
                end
            end
            begin
                cyc = 0;
                while (got < 200 && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    bus.out_ready = 1'($urandom % 2);
                    if (bus.out_valid && bus.out_ready) begin
                        if (exp_r_q.size() == 0) begin
                            chk("rand_unexpected_result", 1, 0);
                        end else begin
                            r = exp_r_q.pop_front();
                            s = exp_s_q.pop_front();
                            chk("rand_r_out", int'(bus.r_out), r);
                            chk("rand_sub", int'(bus.subtracted), s);
                        end
                        got++;
                    end
                end
            end
        join
        chk("rand_count", got, 200);
        chk("rand_queue_empty", exp_r_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
